cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between two result producers: the RS/ALU result port and the load/store buffer result port.
- Each source gets a small FIFO so that a result produced in a conflict cycle is never lost.
- Round-robin grant; the winner is driven onto registered CDB outputs.
- Sits between the RS/LSB result ports and the ROB and RS/LSB forwarding inputs.
- Raises per-source stall outputs so the issue stage stops sending work before a queue can overflow.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_result_fifo.sv | 82 ++++++++
 rtl/cdb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: the queued result entry and source ids.
package cdb_arbiter_pkg;

    localparam int CDB_ROB_WIDTH = 4;

    typedef struct packed {
        logic [31:0]              val;
        logic [CDB_ROB_WIDTH-1:0] dest;
    } cdb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-source result FIFO: a push into a full queue is accepted only when the
// same cycle also pops; clear empties the queue and wins over push/pop.
module cdb_result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int QUEUE_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 push_i,
    input  cdb_entry_t           din_i,
    input  logic                 pop_i,
    output cdb_entry_t           head_o,
    output logic [QUEUE_WIDTH:0] count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int DEPTH = 2 ** QUEUE_WIDTH;
    localparam logic [QUEUE_WIDTH:0] FULL_LVL = (QUEUE_WIDTH + 1)'(DEPTH);

    cdb_entry_t               mem_q [DEPTH];
    logic [QUEUE_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QUEUE_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [QUEUE_WIDTH:0]     count_q, count_d;
    logic                     do_pop_s, do_push_s, do_clr_s;

    assign full_o   = (count_q == FULL_LVL);
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign head_o   = mem_q[rd_ptr_q];
    assign do_clr_s = en_i && clr_i;
    assign do_pop_s  = en_i && !clr_i && pop_i && !empty_o;
    assign do_push_s = en_i && !clr_i && push_i && (!full_o || do_pop_s);

    // Next pointer and occupancy values.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_clr_s) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + QUEUE_WIDTH'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + QUEUE_WIDTH'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (QUEUE_WIDTH + 1)'(do_push_s) - (QUEUE_WIDTH + 1)'(do_pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while the slot is unoccupied.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter between the ALU and LSB result ports with per-source
// FIFOs and registered broadcast. Optional statistics under CDB_STATS_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_WIDTH    = CDB_ROB_WIDTH,
    parameter int QUEUE_WIDTH  = 2,
    parameter int STALL_MARGIN = 2
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 clearIn,
    input  logic                 aluFlag,
    input  logic [31:0]          aluVal,
    input  logic [ROB_WIDTH-1:0] aluDest,
    input  logic                 lsbFlag,
    input  logic [31:0]          lsbVal,
    input  logic [ROB_WIDTH-1:0] lsbDest,
    output logic                 aluStall,
    output logic                 lsbStall,
    output logic                 cdbFlag,
    output logic [31:0]          cdbVal,
    output logic [ROB_WIDTH-1:0] cdbDest,
    output logic                 errOverflow
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]          statConflict,
    output logic [31:0]          statStall
`endif
);

    localparam int DEPTH = 2 ** QUEUE_WIDTH;
    localparam logic [QUEUE_WIDTH:0] STALL_LVL = (QUEUE_WIDTH + 1)'(DEPTH - STALL_MARGIN);

    cdb_entry_t           alu_head_s, lsb_head_s, alu_entry_s, lsb_entry_s;
    logic [QUEUE_WIDTH:0] alu_count_s, lsb_count_s;
    logic                 alu_full_s, lsb_full_s, alu_empty_s, lsb_empty_s;
    logic                 alu_cand_s, lsb_cand_s, conflict_s;
    logic                 grant_alu_s, grant_lsb_s;
    logic                 alu_pop_s, lsb_pop_s, alu_push_s, lsb_push_s;
    logic                 overflow_s;

    logic                 cdb_flag_q, cdb_flag_d;
    logic [31:0]          cdb_val_q, cdb_val_d;
    logic [ROB_WIDTH-1:0] cdb_dest_q, cdb_dest_d;
    cdb_src_e             last_grant_q, last_grant_d;
    logic                 err_q, err_d;

    cdb_result_fifo #(.QUEUE_WIDTH(QUEUE_WIDTH)) u_alu_fifo (
        .clk_i   (clockIn),
        .rst_i   (resetIn),
        .en_i    (readyIn),
        .clr_i   (clearIn),
        .push_i  (alu_push_s),
        .din_i   (cdb_entry_t'{val: aluVal, dest: aluDest}),
        .pop_i   (alu_pop_s),
        .head_o  (alu_head_s),
        .count_o (alu_count_s),
        .full_o  (alu_full_s),
        .empty_o (alu_empty_s)
    );

    cdb_result_fifo #(.QUEUE_WIDTH(QUEUE_WIDTH)) u_lsb_fifo (
        .clk_i   (clockIn),
        .rst_i   (resetIn),
        .en_i    (readyIn),
        .clr_i   (clearIn),
        .push_i  (lsb_push_s),
        .din_i   (cdb_entry_t'{val: lsbVal, dest: lsbDest}),
        .pop_i   (lsb_pop_s),
        .head_o  (lsb_head_s),
        .count_o (lsb_count_s),
        .full_o  (lsb_full_s),
        .empty_o (lsb_empty_s)
    );

    assign aluStall    = (alu_count_s >= STALL_LVL);
    assign lsbStall    = (lsb_count_s >= STALL_LVL);
    assign cdbFlag     = cdb_flag_q;
    assign cdbVal      = cdb_val_q;
    assign cdbDest     = cdb_dest_q;
    assign errOverflow = err_q;

    // Candidate selection (queue head, else same-cycle bypass) and grant.
    always_comb begin
        alu_cand_s  = !alu_empty_s || aluFlag;
        lsb_cand_s  = !lsb_empty_s || lsbFlag;
        alu_entry_s = alu_empty_s ? cdb_entry_t'{val: aluVal, dest: aluDest} : alu_head_s;
        lsb_entry_s = lsb_empty_s ? cdb_entry_t'{val: lsbVal, dest: lsbDest} : lsb_head_s;
        conflict_s  = alu_cand_s && lsb_cand_s;
        if (conflict_s) begin
            grant_alu_s = (last_grant_q == SRC_LSB);
        end else begin
            grant_alu_s = alu_cand_s;
        end
        grant_lsb_s = lsb_cand_s && !grant_alu_s;
        // A granted bypass goes straight to the CDB and never enters the queue.
        alu_pop_s   = grant_alu_s && !alu_empty_s;
        lsb_pop_s   = grant_lsb_s && !lsb_empty_s;
        alu_push_s  = aluFlag && !(grant_alu_s && alu_empty_s);
        lsb_push_s  = lsbFlag && !(grant_lsb_s && lsb_empty_s);
        overflow_s  = (alu_push_s && alu_full_s && !alu_pop_s) ||
                      (lsb_push_s && lsb_full_s && !lsb_pop_s);
    end

    // Next broadcast, round-robin pointer and sticky error.
    always_comb begin
        cdb_flag_d   = cdb_flag_q;
        cdb_val_d    = cdb_val_q;
        cdb_dest_d   = cdb_dest_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        if (!readyIn) begin
            cdb_flag_d = cdb_flag_q;
        end else if (clearIn) begin
            cdb_flag_d = 1'b0;
        end else begin
            if (grant_alu_s) begin
                cdb_flag_d = 1'b1;
                cdb_val_d  = alu_entry_s.val;
                cdb_dest_d = alu_entry_s.dest;
            end else if (grant_lsb_s) begin
                cdb_flag_d = 1'b1;
                cdb_val_d  = lsb_entry_s.val;
                cdb_dest_d = lsb_entry_s.dest;
            end else begin
                cdb_flag_d = 1'b0;
            end
            if (conflict_s) begin
                last_grant_d = grant_alu_s ? SRC_ALU : SRC_LSB;
            end else begin
                last_grant_d = last_grant_q;
            end
            if (overflow_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // Output and arbitration state registers.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            cdb_flag_q   <= 1'b0;
            cdb_val_q    <= 32'h0000_0000;
            cdb_dest_q   <= '0;
            last_grant_q <= SRC_LSB;
            err_q        <= 1'b0;
        end else begin
            cdb_flag_q   <= cdb_flag_d;
            cdb_val_q    <= cdb_val_d;
            cdb_dest_q   <= cdb_dest_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

`ifdef CDB_STATS_EN
    logic [31:0] stat_conflict_q, stat_stall_q;

    assign statConflict = stat_conflict_q;
    assign statStall    = stat_stall_q;

    // Free-running statistics; only reset clears them, clearIn does not.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            stat_conflict_q <= 32'd0;
            stat_stall_q    <= 32'd0;
        end else if (readyIn) begin
            stat_conflict_q <= stat_conflict_q + {31'd0, conflict_s};
            stat_stall_q    <= stat_stall_q + {31'd0, (aluStall || lsbStall)};
        end else begin
            stat_conflict_q <= stat_conflict_q;
            stat_stall_q    <= stat_stall_q;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-level reference model predicts each
// cycle's broadcast, stalls and error flag; CDB_STATS_EN also checks counters.
module tb_cdb_arbiter;

    logic        clockIn = 1'b0;
    logic        resetIn = 1'b0;
    logic        readyIn = 1'b0;
    logic        clearIn = 1'b0;
    logic        aluFlag = 1'b0;
    logic [31:0] aluVal  = 32'd0;
    logic [3:0]  aluDest = 4'd0;
    logic        lsbFlag = 1'b0;
    logic [31:0] lsbVal  = 32'd0;
    logic [3:0]  lsbDest = 4'd0;
    logic        aluStall, lsbStall, cdbFlag, errOverflow;
    logic [31:0] cdbVal;
    logic [3:0]  cdbDest;
`ifdef CDB_STATS_EN
    logic [31:0] statConflict, statStall;
`endif

    cdb_arbiter dut (
        .clockIn     (clockIn),
        .resetIn     (resetIn),
        .readyIn     (readyIn),
        .clearIn     (clearIn),
        .aluFlag     (aluFlag),
        .aluVal      (aluVal),
        .aluDest     (aluDest),
        .lsbFlag     (lsbFlag),
        .lsbVal      (lsbVal),
        .lsbDest     (lsbDest),
        .aluStall    (aluStall),
        .lsbStall    (lsbStall),
        .cdbFlag     (cdbFlag),
        .cdbVal      (cdbVal),
        .cdbDest     (cdbDest),
        .errOverflow (errOverflow)
`ifdef CDB_STATS_EN
        ,
        .statConflict(statConflict),
        .statStall   (statStall)
`endif
    );

    always #5 clockIn = ~clockIn;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queues hold {val, dest}.
    logic [35:0] m_alu[$];
    logic [35:0] m_lsb[$];
    bit          m_last;      // 1 = LSB granted last
    bit          m_flag;
    logic [31:0] m_val;
    logic [3:0]  m_dest;
    bit          m_err;
    logic [31:0] m_conf;
    logic [31:0] m_stall;
    // Expected {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}.
    logic [39:0] sb[$];

    task automatic model_reset();
        m_alu.delete();
        m_lsb.delete();
        m_last  = 1'b1;
        m_flag  = 1'b0;
        m_val   = 32'd0;
        m_dest  = 4'd0;
        m_err   = 1'b0;
        m_conf  = 32'd0;
        m_stall = 32'd0;
        sb.delete();
    endtask

    task automatic do_reset();
        resetIn = 1'b1;
        readyIn = 1'b1;
        clearIn = 1'b0;
        aluFlag = 1'b0;
        lsbFlag = 1'b0;
        @(posedge clockIn);
        #1;
        resetIn = 1'b0;
        model_reset();
    endtask

    // Drive one cycle, advance the model, push the prediction, cross the edge.
    task automatic step(input bit rdy, input bit clr,
                        input bit av, input logic [31:0] aval, input logic [3:0] ad,
                        input bit lv, input logic [31:0] lval, input logic [3:0] ld);
        bit a_has, l_has, g_alu, g_lsb, a_full, l_full, a_pop, l_pop, a_byp, l_byp;
        logic [35:0] a_ent, l_ent;
        readyIn = rdy; clearIn = clr;
        aluFlag = av; aluVal = aval; aluDest = ad;
        lsbFlag = lv; lsbVal = lval; lsbDest = ld;
        if (rdy) begin
            a_has = (m_alu.size() > 0) || av;
            l_has = (m_lsb.size() > 0) || lv;
            if (a_has && l_has) m_conf = m_conf + 32'd1;
            if (m_alu.size() >= 2 || m_lsb.size() >= 2) m_stall = m_stall + 32'd1;
            if (clr) begin
                m_alu.delete();
                m_lsb.delete();
                m_flag = 1'b0;
            end else begin
                a_ent = (m_alu.size() > 0) ? m_alu[0] : {aval, ad};
                l_ent = (m_lsb.size() > 0) ? m_lsb[0] : {lval, ld};
                if (a_has && l_has) begin
                    g_alu  = m_last;
                    m_last = ~g_alu;
                end else begin
                    g_alu = a_has;
                end
                g_lsb  = l_has && !g_alu;
                m_flag = g_alu || g_lsb;
                if (g_alu) {m_val, m_dest} = a_ent;
                else if (g_lsb) {m_val, m_dest} = l_ent;
                a_full = (m_alu.size() == 4);
                l_full = (m_lsb.size() == 4);
                a_byp  = g_alu && (m_alu.size() == 0);
                l_byp  = g_lsb && (m_lsb.size() == 0);
                a_pop  = g_alu && !a_byp;
                l_pop  = g_lsb && !l_byp;
                if (a_pop) void'(m_alu.pop_front());
                if (l_pop) void'(m_lsb.pop_front());
                if (av && !a_byp) begin
                    if (a_full && !a_pop) m_err = 1'b1;
                    else m_alu.push_back({aval, ad});
                end
                if (lv && !l_byp) begin
                    if (l_full && !l_pop) m_err = 1'b1;
                    else m_lsb.push_back({lval, ld});
                end
            end
        end
        sb.push_back({m_flag, m_val, m_dest, (m_alu.size() >= 2), (m_lsb.size() >= 2), m_err});
        @(posedge clockIn);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset: got %h required %h",
                     {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}, 40'd0);
        end
`ifdef CDB_STATS_EN
        n_checks++;
        if ({statConflict, statStall} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h required 0", {statConflict, statStall});
        end
`endif
    endtask

    task automatic test_single();
        logic [39:0] exp;
        do_reset();
        step(1'b1, 1'b0, 1'b1, 32'h11, 4'd3, 1'b0, 32'd0, 4'd0);
        exp = sb.pop_front();
        n_checks++;
        if ({cdbFlag, cdbVal, cdbDest} !== {1'b1, 32'h11, 4'd3} ||
            {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow} !== exp) begin
            n_fail++;
            $display("FAIL single_bcast: got %h required %h",
                     {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}, exp);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        exp = sb.pop_front();
        n_checks++;
        if (cdbFlag !== 1'b0 ||
            {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow} !== exp) begin
            n_fail++;
            $display("FAIL single_idle: got %h required %h",
                     {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}, exp);
        end
    endtask

    task automatic test_conflict();
        logic [39:0] exp;
        logic [35:0] want [2];
        want[0] = {32'hA, 4'd1};
        want[1] = {32'hB, 4'd2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) step(1'b1, 1'b0, 1'b1, 32'hA, 4'd1, 1'b1, 32'hB, 4'd2);
            else        step(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
            exp = sb.pop_front();
            n_checks++;
            if ((i < 2 && {cdbFlag, cdbVal, cdbDest} !== {1'b1, want[i]}) ||
                {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow} !== exp) begin
                n_fail++;
                $display("FAIL conflict[%0d]: got %h required %h", i,
                         {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}, exp);
            end
        end
`ifdef CDB_STATS_EN
        n_checks++;
        if (statConflict !== 32'd1) begin
            n_fail++;
            $display("FAIL conflict_stat: got %0d required 1", statConflict);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [39:0] exp;
        bit saw_stall = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 4)
                step(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 4'(i), 1'b1, 32'h200 + 32'(i), 4'(8 + i));
            else
                step(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
            exp = sb.pop_front();
            saw_stall = saw_stall | aluStall;
            n_checks++;
            // Strict alternation: ALU value k at even slot 2k, LSB value k at 2k+1.
            if (cdbVal !== ((i % 2 == 0) ? 32'h100 + 32'(i / 2) : 32'h200 + 32'(i / 2)) ||
                {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow} !== exp) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h required %h", i,
                         {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}, exp);
            end
        end
        n_checks++;
        if (saw_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_stall: got %b required 1", saw_stall);
        end
    endtask

    task automatic test_overflow();
        logic [39:0] exp;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 10)
                step(1'b1, 1'b0, 1'b1, 32'h300 + 32'(i), 4'(i), 1'b1, 32'h400 + 32'(i), 4'(15 - i));
            else
                step(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
            exp = sb.pop_front();
            n_checks++;
            if ({cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow} !== exp) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got %h required %h", i,
                         {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}, exp);
            end
        end
        step(1'b1, 1'b1, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        void'(sb.pop_front());
        n_checks++;
        if (errOverflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b required 1", errOverflow);
        end
        do_reset();
        n_checks++;
        if (errOverflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_reset: got %b required 0", errOverflow);
        end
    endtask

    task automatic test_clear();
        logic [39:0] exp;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h500 + 32'(i), 4'(i), 1'b1, 32'h600 + 32'(i), 4'(i));
            void'(sb.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), (i == 0), 32'h777, 4'd7, 1'b0, 32'd0, 4'd0);
            exp = sb.pop_front();
            n_checks++;
            if ({cdbFlag, aluStall, lsbStall} !== 3'b000 ||
                {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow} !== exp) begin
                n_fail++;
                $display("FAIL clear[%0d]: got %h required %h", i,
                         {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}, exp);
            end
        end
    endtask

    task automatic test_ready_freeze();
        logic [39:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h700 + 32'(i), 4'(i), 1'b1, 32'h800 + 32'(i), 4'(i));
            void'(sb.pop_front());
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 3)
                step(1'b0, (i == 1), 1'b1, 32'hDEAD, 4'd9, 1'b1, 32'hBEEF, 4'd10);
            else
                step(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
            exp = sb.pop_front();
            n_checks++;
            if ({cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow} !== exp) begin
                n_fail++;
                $display("FAIL freeze[%0d]: got %h required %h", i,
                         {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [39:0] exp;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 2) != 0), $urandom, 4'($urandom),
                 ($urandom_range(0, 2) != 0), $urandom, 4'($urandom));
            exp = sb.pop_front();
            n_checks++;
            if ({cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow} !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h", i,
                         {cdbFlag, cdbVal, cdbDest, aluStall, lsbStall, errOverflow}, exp);
            end
        end
`ifdef CDB_STATS_EN
        n_checks++;
        if ({statConflict, statStall} !== {m_conf, m_stall}) begin
            n_fail++;
            $display("FAIL random_stats: got %0d/%0d required %0d/%0d",
                     statConflict, statStall, m_conf, m_stall);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_back_to_back();
        test_overflow();
        test_clear();
        test_ready_freeze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
